// File: rtl/ifq_multi_if.sv
// Fetch-queue bus: icache request/return on one side, dispatch slots on the other.
// "master" is the fetch queue; "slave" is the icache/dispatch environment.
interface ifq_multi_if #(
  parameter int ADDR_W     = 32,
  parameter int INST_W     = 32,
  parameter int LINE_INSTS = 4,
  parameter int DISP_W     = 2
);
  logic [ADDR_W-1:0]               icache_pcin;
  logic                            icache_ren;
  logic                            icache_abort;
  logic [LINE_INSTS*INST_W-1:0]    icache_dout;
  logic                            icache_dout_valid;
  logic [DISP_W*INST_W-1:0]        dispatch_inst;
  logic [DISP_W-1:0]               dispatch_valid;
  logic [ADDR_W-1:0]               dispatch_pcout_plus4;
  logic                            dispatch_empty;
  logic [$clog2(DISP_W+1)-1:0]     dispatch_ren_cnt;
  logic [ADDR_W-1:0]               dispatch_branch_addr;
  logic                            dispatch_branch_valid;

  modport master (
    output icache_pcin, icache_ren, icache_abort,
    output dispatch_inst, dispatch_valid, dispatch_pcout_plus4, dispatch_empty,
    input  icache_dout, icache_dout_valid,
    input  dispatch_ren_cnt, dispatch_branch_addr, dispatch_branch_valid
  );
  modport slave (
    input  icache_pcin, icache_ren, icache_abort,
    input  dispatch_inst, dispatch_valid, dispatch_pcout_plus4, dispatch_empty,
    output icache_dout, icache_dout_valid,
    output dispatch_ren_cnt, dispatch_branch_addr, dispatch_branch_valid
  );
endinterface

// File: rtl/ifq_multi.sv
// Instruction fetch queue: DEPTH-line circular buffer fed by whole icache lines,
// up to DISP_W instructions per cycle to dispatch, same-cycle bypass when empty.
module ifq_multi_slot #(
  parameter int INST_W     = 32,
  parameter int LINE_INSTS = 4,
  parameter int DEPTH      = 4,
  parameter int LANE       = 0
) (
  input  logic                                       vld_i,
  input  logic                                       byp_i,
  input  logic [$clog2(DEPTH*LINE_INSTS)-1:0]        rptr_i,
  input  logic [LINE_INSTS-1:0][INST_W-1:0]          line_i,
  input  logic [DEPTH-1:0][LINE_INSTS-1:0][INST_W-1:0] mem_i,
  output logic [INST_W-1:0]                          inst_o
);
  localparam int OFF_W = $clog2(LINE_INSTS);
  localparam int IW    = $clog2(DEPTH*LINE_INSTS);
  logic [IW-1:0] idx;

  // index wraps modulo the buffer, so line and buffer wrap come for free
  assign idx = rptr_i + IW'(LANE);
  assign inst_o = !vld_i ? '0 :
                  byp_i  ? line_i[idx[OFF_W-1:0]] :
                           mem_i[idx[IW-1:OFF_W]][idx[OFF_W-1:0]];
endmodule

module ifq_multi #(
  parameter int ADDR_W     = 32,
  parameter int INST_W     = 32,
  parameter int LINE_INSTS = 4,
  parameter int DEPTH      = 4,
  parameter int DISP_W     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  ifq_multi_if.master ifq
);
  localparam int OFF_W = $clog2(LINE_INSTS);
  localparam int LN_W  = $clog2(DEPTH);
  localparam int WP    = LN_W + 1;
  localparam int RP    = LN_W + OFF_W + 1;
  localparam logic [RP-1:0] DISP_R = RP'(DISP_W);

  typedef enum logic {IDLE, WAIT} st_t;
  st_t st_q, st_d;
  logic [WP-1:0]     wptr_q, wptr_d;
  logic [RP-1:0]     rptr_q, rptr_d;
  logic [ADDR_W-1:0] pcin_q, pcin_d, pcout_q, pcout_d;
  logic [DEPTH-1:0][LINE_INSTS-1:0][INST_W-1:0] mem_q;
  logic [LINE_INSTS-1:0][INST_W-1:0] line;
  logic [DISP_W-1:0][INST_W-1:0]     slot;
  logic [DISP_W-1:0] vld;
  logic [WP-1:0] lines_used;
  logic [RP-1:0] inst_count, room, avail, take, cnt_ext;
  logic br, wr, byp, ren, abort;

  assign line       = ifq.icache_dout;
  assign br         = ifq.dispatch_branch_valid;
  assign lines_used = wptr_q - rptr_q[RP-1:OFF_W];
  // after a redirect rptr sits mid-line in a line not yet written: nothing buffered
  assign inst_count = (lines_used == '0) ? '0 : ({wptr_q, {OFF_W{1'b0}}} - rptr_q);
  assign wr         = (st_q == WAIT) && ifq.icache_dout_valid && !br;
  assign byp        = wr && (inst_count == '0);
  assign room       = RP'(LINE_INSTS) - RP'(rptr_q[OFF_W-1:0]);
  assign cnt_ext    = RP'(ifq.dispatch_ren_cnt);

  always_comb begin
    avail = '0;
    if (!br) begin
      if (byp) avail = (room < DISP_R) ? room : DISP_R;
      else     avail = (inst_count < DISP_R) ? inst_count : DISP_R;
    end
    take = (cnt_ext < avail) ? cnt_ext : avail;
    for (int i = 0; i < DISP_W; i++) vld[i] = RP'(i) < avail;
  end

  always_comb begin
    st_d    = st_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q + take;
    pcin_d  = pcin_q;
    pcout_d = pcout_q + ADDR_W'({take, 2'b00});
    ren     = 1'b0;
    abort   = 1'b0;
    case (st_q)
      IDLE: if (!br && lines_used < WP'(DEPTH)) begin
        ren  = 1'b1;
        st_d = WAIT;
      end
      WAIT: if (br) abort = 1'b1;
      else begin
        ren = 1'b1;
        if (ifq.icache_dout_valid) begin
          wptr_d = wptr_q + WP'(1);
          pcin_d = pcin_q + ADDR_W'(LINE_INSTS*4);
          if (!(lines_used + WP'(1) < WP'(DEPTH))) st_d = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
    if (br) begin
      st_d    = IDLE;
      wptr_d  = '0;
      rptr_d  = RP'(ifq.dispatch_branch_addr[OFF_W+1:2]);
      pcin_d  = {ifq.dispatch_branch_addr[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
      pcout_d = {ifq.dispatch_branch_addr[ADDR_W-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q    <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      pcin_q  <= '0;
      pcout_q <= '0;
    end else begin
      st_q    <= st_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      pcin_q  <= pcin_d;
      pcout_q <= pcout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q[WP-2:0]] <= line;
  end

  for (genvar g = 0; g < DISP_W; g++) begin : g_slot
    ifq_multi_slot #(.INST_W(INST_W), .LINE_INSTS(LINE_INSTS), .DEPTH(DEPTH), .LANE(g)) u_slot (
      .vld_i (vld[g]),
      .byp_i (byp),
      .rptr_i(rptr_q[RP-2:0]),
      .line_i(line),
      .mem_i (mem_q),
      .inst_o(slot[g])
    );
  end

  // IDLE with room requests combinationally, so hold it off while in reset
  assign ifq.icache_ren           = ren && reset_n;
  assign ifq.icache_abort         = abort && reset_n;
  assign ifq.icache_pcin          = pcin_q;
  assign ifq.dispatch_inst        = slot;
  assign ifq.dispatch_valid       = vld;
  assign ifq.dispatch_empty       = (avail == '0);
  assign ifq.dispatch_pcout_plus4 = pcout_q + ADDR_W'(4);
endmodule
